// File: rtl/leading_count_pipe.sv
// Two-stage leading-zero/leading-one counter with a per-item tag and scan direction.
// Latency 2 cycles; a single global stall (advance) freezes every stage when the output is blocked.
module leading_count_pipe #(
    parameter int  WIDTH      = 32,
    parameter int  GROUP_W    = 8,
    parameter int  TAG_W      = 4,
    localparam int COUNT_BITS = $clog2(WIDTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [WIDTH-1:0]      data_i,
    input  logic                  ones_i,
    input  logic                  msb_first_i,
    input  logic [TAG_W-1:0]      tag_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [COUNT_BITS-1:0] count_o,
    output logic                  none_o,
    output logic [TAG_W-1:0]      tag_o
);
    localparam int NG  = WIDTH / GROUP_W;
    localparam int LCW = (GROUP_W > 1) ? $clog2(GROUP_W) : 1;

    logic                      w_advance;
    logic [WIDTH-1:0]          w_scan;
    logic [NG-1:0]             w_am;
    logic [NG-1:0][LCW-1:0]    w_lc;
    logic [COUNT_BITS-1:0]     w_count;
    logic                      w_none;

    logic                      r_s1_vld;
    logic [NG-1:0]             r_s1_am;
    logic [NG-1:0][LCW-1:0]    r_s1_lc;
    logic [TAG_W-1:0]          r_s1_tag;

    logic                      r_out_vld;
    logic [COUNT_BITS-1:0]     r_count;
    logic                      r_none;
    logic [TAG_W-1:0]          r_tag;

    assign w_advance  = !r_out_vld || out_ready_i;
    assign in_ready_o = w_advance && rst_ni;

    // Reorder into scan order and flip so a matching bit is always 0.
    always_comb begin
        w_scan = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_scan[i] = (msb_first_i ? data_i[WIDTH-1-i] : data_i[i]) ^ ones_i;
        end
    end

    always_comb begin
        w_am = '1;
        w_lc = '0;
        for (int g = 0; g < NG; g++) begin
            for (int b = GROUP_W - 1; b >= 0; b--) begin
                if (w_scan[g*GROUP_W + b]) begin
                    w_am[g] = 1'b0;
                    w_lc[g] = LCW'(b);
                end
            end
        end
    end

    // Walking down means the lowest non-matching group is assigned last and wins.
    always_comb begin
        w_count = '0;
        w_none  = 1'b1;
        for (int k = NG - 1; k >= 0; k--) begin
            if (!r_s1_am[k]) begin
                w_count = COUNT_BITS'(k*GROUP_W) + COUNT_BITS'(r_s1_lc[k]);
                w_none  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_s1_vld  <= 1'b0;
            r_out_vld <= 1'b0;
            r_count   <= '0;
            r_none    <= 1'b0;
            r_tag     <= '0;
        end else if (w_advance) begin
            r_s1_vld  <= in_valid_i;
            r_out_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_count <= w_count;
                r_none  <= w_none;
                r_tag   <= r_s1_tag;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (in_ready_o && in_valid_i) begin
            r_s1_am  <= w_am;
            r_s1_lc  <= w_lc;
            r_s1_tag <= tag_i;
        end
    end

    assign out_valid_o = r_out_vld;
    assign count_o     = r_count;
    assign none_o      = r_none;
    assign tag_o       = r_tag;

endmodule

// File: tb/tb_leading_count_pipe.sv
// Bench for leading_count_pipe at WIDTH=8, GROUP_W=4, TAG_W=4 with a bit-serial reference scoreboard.
module tb_leading_count_pipe;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] data = '0;
    logic       ones = 1'b0;
    logic       msb = 1'b0;
    logic [3:0] tag = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [2:0] count;
    logic       none;
    logic [3:0] tag_o;

    typedef struct packed {
        logic [2:0] count;
        logic       none;
        logic [3:0] tag;
    } res_t;

    res_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    leading_count_pipe #(.WIDTH(8), .GROUP_W(4), .TAG_W(4)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .data_i     (data),
        .ones_i     (ones),
        .msb_first_i(msb),
        .tag_i      (tag),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .count_o    (count),
        .none_o     (none),
        .tag_o      (tag_o)
    );

    function automatic res_t model(input logic [7:0] d, input logic o, input logic m, input logic [3:0] t);
        res_t r;
        r.count = '0;
        r.none  = 1'b1;
        r.tag   = t;
        for (int i = 0; i < 8; i++) begin
            logic b;
            b = m ? d[7-i] : d[i];
            if (r.none && (b != o)) begin
                r.none  = 1'b0;
                r.count = 3'(i);
            end
        end
        return r;
    endfunction

    // Scoreboard: record accepted items, compare every emitted result in order.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: got count=%0d none=%0d tag=%0d, required no result",
                             count, none, tag_o);
                end else begin
                    res_t e;
                    e = sb.pop_front();
                    if ({count, none, tag_o} !== {e.count, e.none, e.tag}) begin
                        n_fail++;
                        $display("FAIL sb_result: got count=%0d none=%0d tag=%0d, required count=%0d none=%0d tag=%0d",
                                 count, none, tag_o, e.count, e.none, e.tag);
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(model(data, ones, msb, tag));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] d, input logic o, input logic m, input logic [3:0] t);
        in_valid = 1'b1;
        data     = d;
        ones     = o;
        msb      = m;
        tag      = t;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %0b, required 0", out_valid); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL rst_count: got %0d, required 0", count); end
        n_checks++; if (none !== 1'b0) begin n_fail++; $display("FAIL rst_none: got %0b, required 0", none); end
        n_checks++; if (tag_o !== 4'd0) begin n_fail++; $display("FAIL rst_tag: got %0d, required 0", tag_o); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready_low: got %0b, required 0", in_ready); end
        rst_n = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready_release: got %0b, required 1", in_ready); end
    endtask

    task automatic test_single(input logic [7:0] d, input logic o, input logic m, input logic [3:0] t,
                               input logic [2:0] ec, input logic en);
        out_ready = 1'b1;
        drive(d, o, m, t);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_in_ready: got %0b, required 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early: got out_valid=%0b, required 0", out_valid); end
        tick();
        n_checks++;
        if ({out_valid, count, none, tag_o} !== {1'b1, ec, en, t}) begin
            n_fail++;
            $display("FAIL single_result d=%h: got vld=%0b count=%0d none=%0b tag=%0d, required vld=1 count=%0d none=%0b tag=%0d",
                     d, out_valid, count, none, tag_o, ec, en, t);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int got_tag[$];
        int got_cyc[$];
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c < 6) begin
                drive(8'($urandom), 1'($urandom), 1'($urandom), 4'(c));
                n_checks++;
                if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready c=%0d: got %0b, required 1", c, in_ready); end
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (out_valid) begin
                got_tag.push_back(int'(tag_o));
                got_cyc.push_back(c);
            end
            tick();
        end
        n_checks++;
        if (got_tag.size() != 6) begin
            n_fail++; $display("FAIL b2b_count: got %0d results, required 6", got_tag.size());
        end else begin
            n_checks++;
            if (got_cyc[5] - got_cyc[0] != 5) begin
                n_fail++; $display("FAIL b2b_consecutive: got span %0d cycles, required 5", got_cyc[5] - got_cyc[0]);
            end
            for (int i = 0; i < 6; i++) begin
                n_checks++;
                if (got_tag[i] != i) begin n_fail++; $display("FAIL b2b_tag_order i=%0d: got %0d, required %0d", i, got_tag[i], i); end
            end
        end
    endtask

    task automatic test_backpressure();
        int   idx = 0;
        int   accepted = 0;
        bit   snap_set = 0;
        res_t snap;
        int   guard = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            drive(8'(8'h80 >> idx), 1'b0, 1'(idx), 4'(8 + idx));
            @(negedge clk);
            if (out_valid) begin
                if (!snap_set) begin
                    snap = '{count, none, tag_o};
                    snap_set = 1;
                end else begin
                    n_checks++;
                    if ({count, none, tag_o} !== {snap.count, snap.none, snap.tag}) begin
                        n_fail++;
                        $display("FAIL bp_hold c=%0d: got count=%0d none=%0b tag=%0d, required count=%0d none=%0b tag=%0d",
                                 c, count, none, tag_o, snap.count, snap.none, snap.tag);
                    end
                end
            end
            if (in_ready) begin
                accepted++;
                idx++;
            end
            tick();
        end
        n_checks++; if (accepted != 2) begin n_fail++; $display("FAIL bp_accepted: got %0d, required 2", accepted); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %0b, required 0", in_ready); end
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid: got %0b, required 1", out_valid); end
        out_ready = 1'b1;
        while (idx < 5 && guard < 20) begin
            drive(8'(8'h80 >> idx), 1'b0, 1'(idx), 4'(8 + idx));
            @(negedge clk);
            if (in_ready) idx++;
            tick();
            guard++;
        end
        in_valid = 1'b0;
        guard = 0;
        while ((sb.size() != 0 || out_valid) && guard < 20) begin
            tick();
            guard++;
        end
        n_checks++; if (idx != 5) begin n_fail++; $display("FAIL bp_all_sent: got %0d, required 5", idx); end
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL bp_drain: got %0d pending, required 0", sb.size()); end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        drive(8'h0F, 1'b0, 1'b1, 4'd1);
        tick();
        drive(8'h01, 1'b1, 1'b0, 4'd2);
        tick();
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_loaded: got %0b, required 1", out_valid); end
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_in_ready: got %0b, required 0", in_ready); end
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_flushed: got %0b, required 0", out_valid); end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale c=%0d: got out_valid=%0b tag=%0d, required 0", c, out_valid, tag_o); end
            tick();
        end
        test_single(8'b0000_0100, 1'b0, 1'b0, 4'd7, 3'd2, 1'b0);
    endtask

    task automatic test_random();
        int   n_sent = 0;
        int   cycles = 0;
        bit   have = 0;
        int   guard = 0;
        logic [7:0] d;
        logic o, m;
        while (n_sent < 10000 && cycles < 60000) begin
            if (!have) begin
                o = 1'($urandom);
                m = 1'($urandom);
                case ($urandom_range(0, 3))
                    0:       d = o ? 8'hFF : 8'h00;
                    1:       d = (o ? 8'hFF : 8'h00) ^ 8'(1 << $urandom_range(0, 7));
                    default: d = 8'($urandom);
                endcase
                have = 1;
            end
            drive(d, o, m, 4'($urandom));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (in_valid && in_ready) begin
                n_sent++;
                have = 0;
            end
            tick();
            cycles++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        while ((sb.size() != 0 || out_valid) && guard < 20) begin
            tick();
            guard++;
        end
        n_checks++; if (n_sent != 10000) begin n_fail++; $display("FAIL rand_sent: got %0d, required 10000", n_sent); end
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL rand_drain: got %0d pending, required 0", sb.size()); end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single(8'b0001_0000, 1'b0, 1'b1, 4'd3, 3'd3, 1'b0);
        test_single(8'b0001_0000, 1'b0, 1'b0, 4'd3, 3'd4, 1'b0);
        test_single(8'h00, 1'b0, 1'b1, 4'd5, 3'd0, 1'b1);
        test_single(8'hFF, 1'b1, 1'b0, 4'd6, 3'd0, 1'b1);
        test_single(8'hFE, 1'b1, 1'b0, 4'd9, 3'd0, 1'b0);
        test_single(8'b1110_1111, 1'b1, 1'b1, 4'd10, 3'd3, 1'b0);
        test_single(8'b1000_0000, 1'b0, 1'b0, 4'd11, 3'd7, 1'b0);
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
